lcm_gcd_engine: RTL and testbench

Parametrised successor to the fixed 8-bit LCM processor. Computes LCM by repeated addition or GCD by repeated subtraction. Operand width is configurable and the mode is selected per operation. Adds busy/done status, an overflow flag, zero-operand handling and an iteration count. The block is a standalone arithmetic engine driven by a go pulse. It is instantiated wherever the single-mode processor was used.

---
 rtl/lcm_pkg.sv | 22 ++
 rtl/lcm_step.sv | 45 ++++
 rtl/lcm_gcd_engine.sv | 129 ++++++++++++
 tb/tb_lcm_gcd_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcm_pkg.sv
// Shared types and helpers for the LCM/GCD engine.
package lcm_pkg;

   typedef enum logic {
      IDLE,
      CALC
   } state_e;

   localparam logic MODE_LCM = 1'b0;
   localparam logic MODE_GCD = 1'b1;

   // Increment that sticks at the all-ones value of a w-bit counter.
   function automatic logic [63:0] sat_inc(
      input logic [63:0] v,
      input int unsigned w
   );
      logic [63:0] top;
      top = (64'd1 << w) - 64'd1;
      return (v == top) ? v : v + 64'd1;
   endfunction

endpackage

// File: rtl/lcm_step.sv
// One LCM/GCD iteration: next operand values plus status flags.
module lcm_step
   import lcm_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] x0_i,
   input  logic [WIDTH-1:0] y0_i,
   input  logic             mode_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             eq_o,
   output logic             zero_o,
   output logic             carry_o
);

   logic             lt;
   logic [WIDTH:0]   sum;

   assign lt     = a_i < b_i;
   assign eq_o   = a_i == b_i;
   assign zero_o = (a_i == '0) || (b_i == '0);

   always_comb begin
      a_o     = a_i;
      b_o     = b_i;
      carry_o = 1'b0;
      sum     = '0;
      if (mode_i == MODE_LCM) begin
         // Extra adder bit exposes the overflow of the smaller multiple.
         sum = lt ? ({1'b0, a_i} + {1'b0, x0_i})
                  : ({1'b0, b_i} + {1'b0, y0_i});
         carry_o = sum[WIDTH];
         if (lt) a_o = sum[WIDTH-1:0];
         else    b_o = sum[WIDTH-1:0];
      end else if (lt) begin
         b_o = b_i - a_i;
      end else begin
         a_o = a_i - b_i;
      end
   end

endmodule

// File: rtl/lcm_gcd_engine.sv
// Iterative LCM (repeated addition) / GCD (repeated subtraction) engine.
module lcm_gcd_engine
   import lcm_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int ITER_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go_i,
   input  logic              mode_i,
   input  logic [WIDTH-1:0]  x_i,
   input  logic [WIDTH-1:0]  y_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              ovf_o,
   output logic [WIDTH-1:0]  d_o,
   output logic [ITER_W-1:0] cycles_o
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]   x0_q, x0_d, y0_q, y0_d;
   logic               mode_q, mode_d;
   logic [ITER_W-1:0]  iter_q, iter_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;
   logic [ITER_W-1:0]  cyc_q, cyc_d;

   logic [WIDTH-1:0]   step_a, step_b;
   logic               eq, zero, carry;

   lcm_step #(.WIDTH(WIDTH)) u_step (
      .a_i     (a_q),
      .b_i     (b_q),
      .x0_i    (x0_q),
      .y0_i    (y0_q),
      .mode_i  (mode_q),
      .a_o     (step_a),
      .b_o     (step_b),
      .eq_o    (eq),
      .zero_o  (zero),
      .carry_o (carry)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      mode_d  = mode_q;
      iter_d  = iter_q;
      d_d     = d_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      cyc_d   = cyc_q;
      case (state_q)
         IDLE: begin
            if (go_i) begin
               a_d     = x_i;
               b_d     = y_i;
               x0_d    = x_i;
               y0_d    = y_i;
               mode_d  = mode_i;
               iter_d  = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (zero || eq || carry) begin
               state_d = IDLE;
               done_d  = 1'b1;
               cyc_d   = iter_q;
               ovf_d   = 1'b0;
               if (zero)
                  d_d = (mode_q == MODE_LCM) ? '0 : (a_q | b_q);
               else if (eq)
                  d_d = a_q;
               else begin
                  d_d   = '0;
                  ovf_d = 1'b1;
               end
            end else begin
               a_d    = step_a;
               b_d    = step_b;
               iter_d = ITER_W'(sat_inc(64'(iter_q), ITER_W));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         x0_q    <= '0;
         y0_q    <= '0;
         mode_q  <= MODE_LCM;
         iter_q  <= '0;
         d_q     <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         mode_q  <= mode_d;
         iter_q  <= iter_d;
         d_q     <= d_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         cyc_q   <= cyc_d;
      end
   end

   assign busy_o   = (state_q == CALC);
   assign done_o   = done_q;
   assign ovf_o    = ovf_q;
   assign d_o      = d_q;
   assign cycles_o = cyc_q;

endmodule

// File: tb/tb_lcm_gcd_engine.sv
// Randomised bench for lcm_gcd_engine at WIDTH=8 and WIDTH=16.
module tb_lcm_gcd_engine;
   import lcm_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        go, mode, sel;
   logic [15:0] xin, yin;

   logic        busy8, done8, ovf8;
   logic [7:0]  d8;
   logic [15:0] cyc8;
   logic        busy16, done16, ovf16;
   logic [15:0] d16;
   logic [15:0] cyc16;

   logic        busy, done, ovf;
   logic [15:0] dout, cyc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lcm_gcd_engine #(.WIDTH(8), .ITER_W(16)) dut8 (
      .clk      (clk),
      .rst      (rst),
      .go_i     (go & ~sel),
      .mode_i   (mode),
      .x_i      (xin[7:0]),
      .y_i      (yin[7:0]),
      .busy_o   (busy8),
      .done_o   (done8),
      .ovf_o    (ovf8),
      .d_o      (d8),
      .cycles_o (cyc8)
   );

   lcm_gcd_engine #(.WIDTH(16), .ITER_W(16)) dut16 (
      .clk      (clk),
      .rst      (rst),
      .go_i     (go & sel),
      .mode_i   (mode),
      .x_i      (xin),
      .y_i      (yin),
      .busy_o   (busy16),
      .done_o   (done16),
      .ovf_o    (ovf16),
      .d_o      (d16),
      .cycles_o (cyc16)
   );

   assign busy = sel ? busy16 : busy8;
   assign done = sel ? done16 : done8;
   assign ovf  = sel ? ovf16 : ovf8;
   assign dout = sel ? d16 : {8'd0, d8};
   assign cyc  = sel ? cyc16 : cyc8;

   task automatic chk(input string tag,
                      input longint unsigned got,
                      input longint unsigned exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // Reference from number theory: gcd via Euclid, lcm = x*y/gcd.
   function automatic void model(
      input  bit                m,
      input  longint unsigned   x,
      input  longint unsigned   y,
      input  int                w,
      output longint unsigned   d,
      output bit                ov,
      output longint unsigned   cy
   );
      longint unsigned mx, a, b, t, g, s, l, p, q;
      mx = 64'd1 << w;
      d  = 0;
      ov = 0;
      cy = 0;
      if (x == 0 || y == 0) begin
         d = m ? (x | y) : 0;
         return;
      end
      a = x;
      b = y;
      s = 0;
      while (b != 0) begin
         s += a / b;
         t = a % b;
         a = b;
         b = t;
      end
      g = a;
      if (m) begin
         d  = g;
         cy = s - 1;
         return;
      end
      l = (x / g) * y;
      if (l < mx) begin
         d  = l;
         cy = l / x + l / y - 2;
      end else begin
         ov = 1;
         p  = (mx - 1) / x;
         q  = (mx - 1) / y;
         if (p * x < q * y) cy = (p - 1) + (p * x) / y;
         else               cy = (q - 1) + (q * y) / x;
      end
      if (cy > 65535) cy = 65535;
   endfunction

   task automatic start(input bit m, input int unsigned x, input int unsigned y);
      go   = 1'b1;
      mode = m;
      xin  = 16'(x);
      yin  = 16'(y);
      @(negedge clk);
      go   = 1'b0;
   endtask

   task automatic wait_done(input int n0, output int lat);
      int n;
      bit seen;
      n    = n0;
      seen = 0;
      while (!seen && n < 5000) begin
         @(negedge clk);
         n++;
         chk("busy_done_overlap", longint'(busy & done), 0);
         if (done) seen = 1;
      end
      if (!seen) chk("timeout", 0, 1);
      lat = n;
   endtask

   task automatic check_res(input bit m, input int unsigned x,
                            input int unsigned y, input int lat);
      longint unsigned ed, ec;
      bit eo;
      model(m, x, y, sel ? 16 : 8, ed, eo, ec);
      chk(m ? "gcd_d" : "lcm_d", dout, ed);
      chk("ovf", longint'(ovf), longint'(eo));
      chk("cycles", cyc, ec);
      chk("latency", longint'(lat), ec + 2);
   endtask

   task automatic run(input bit s, input bit m,
                      input int unsigned x, input int unsigned y);
      int lat;
      sel = s;
      start(m, x, y);
      wait_done(1, lat);
      check_res(m, x, y, lat);
      @(negedge clk);
      chk("done_pulse", longint'(done), 0);
   endtask

   task automatic b2b(input bit s);
      int lat;
      sel = s;
      start(MODE_GCD, 9, 9);
      wait_done(1, lat);
      check_res(MODE_GCD, 9, 9, lat);
      start(MODE_LCM, s ? 255 : 5, s ? 254 : 7);
      wait_done(1, lat);
      check_res(MODE_LCM, s ? 255 : 5, s ? 254 : 7, lat);
      @(negedge clk);
      chk("done_pulse", longint'(done), 0);
   endtask

   initial begin
      int lat;
      int unsigned rx, ry;
      rst  = 1'b1;
      go   = 1'b0;
      mode = 1'b0;
      sel  = 1'b0;
      xin  = '0;
      yin  = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy8", longint'(busy8), 0);
      chk("rst_done8", longint'(done8), 0);
      chk("rst_d8", d8, 0);
      chk("rst_cyc16", cyc16, 0);
      rst = 1'b0;
      @(negedge clk);

      run(0, MODE_LCM, 4, 6);
      chk("lcm46_lit", dout, 12);
      run(0, MODE_GCD, 48, 18);
      run(0, MODE_GCD, 12, 18);
      run(0, MODE_LCM, 200, 150);
      chk("ovf_lit", longint'(ovf), 1);
      run(0, MODE_LCM, 0, 9);
      run(0, MODE_GCD, 0, 9);
      chk("gcd09_lit", dout, 9);
      run(0, MODE_GCD, 0, 0);

      sel = 0;
      start(MODE_LCM, 4, 6);
      go   = 1'b1;
      mode = MODE_GCD;
      xin  = 16'd9;
      yin  = 16'd3;
      @(negedge clk);
      go = 1'b0;
      wait_done(2, lat);
      check_res(MODE_LCM, 4, 6, lat);
      @(negedge clk);

      start(MODE_LCM, 4, 6);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", longint'(busy), 0);
      chk("mid_rst_done", longint'(done), 0);
      chk("mid_rst_d", dout, 0);
      chk("mid_rst_ovf", longint'(ovf), 0);
      chk("mid_rst_cyc", cyc, 0);
      run(0, MODE_LCM, 3, 5);
      chk("lcm35_lit", dout, 15);

      b2b(0);
      chk("lcm57_lit", dout, 35);
      b2b(1);
      chk("lcm_w16_lit", dout, 64770);

      for (int i = 0; i < 30; i++) begin
         rx = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 255);
         ry = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 255);
         run(0, 1'($urandom % 2), rx, ry);
      end
      for (int i = 0; i < 10; i++) begin
         rx = $urandom_range(0, 400);
         ry = $urandom_range(0, 400);
         run(1, 1'($urandom % 2), rx, ry);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
